// File: rtl/execute.sv
// Execute stage: one ALU operation per valid instruction, result flags,
// conditional PC adjustment against the architectural flags, and a single
// output register bank feeding the write stage. Back-pressure from the
// write stage is forwarded combinationally to the read stage.
module execute #(
  parameter int W           = 32,
  parameter int NR          = 32,
  parameter int FLAGS_INDEX = NR - 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NR-1:0][W-1:0]   registers,
  input  logic [W-1:0]           ini_pc,
  input  logic [W-1:0]           ini_adjustment,
  input  logic [W-1:0]           ini_left_value,
  input  logic [W-1:0]           ini_right_value,
  input  logic [4:0]             ini_destination,
  input  logic [3:0]             ini_operation,
  input  logic [2:0]             ini_adjustment_operation,
  input  logic                   ini_destination_is_memory,
  input  logic                   ini_has_flushed,
  input  logic                   ini_is_valid,
  output logic                   ini_hold,
  output logic [W-1:0]           outi_pc,
  output logic [W-1:0]           outi_adjustment,
  output logic [W-1:0]           outi_destination_value,
  output logic [4:0]             outi_destination,
  output logic [3:0]             outi_flags,
  output logic                   outi_destination_is_memory,
  output logic                   outi_has_flushed,
  output logic                   outi_is_valid,
  input  logic                   outi_hold
);

  localparam int SHW = $clog2(W);

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_SHL = 4'd5,
    OP_SHR = 4'd6,
    OP_ASR = 4'd7,
    OP_MUL = 4'd8,
    OP_MOV = 4'd9
  } alu_op_e;

  typedef enum logic [2:0] {
    ADJ_NEVER  = 3'b000,
    ADJ_ALWAYS = 3'b001,
    ADJ_Z      = 3'b010,
    ADJ_NZ     = 3'b011,
    ADJ_N      = 3'b100,
    ADJ_NN     = 3'b101,
    ADJ_C      = 3'b110,
    ADJ_NC     = 3'b111
  } adj_op_e;

  logic [W-1:0]   w_a;
  logic [W-1:0]   w_b;
  logic [SHW-1:0] w_shamt;
  logic [W:0]     w_sum;
  logic [W:0]     w_diff;
  logic [W:0]     w_shl;
  logic [W:0]     w_shr;
  logic [W:0]     w_asr;
  logic [W-1:0]   w_result;
  logic           w_carry;
  logic           w_overflow;
  logic           w_flag_en;
  logic [3:0]     w_flags;
  logic [3:0]     w_arch_flags;
  logic           w_take;
  logic [W-1:0]   w_adjustment;
  logic           w_unused;

  assign w_a     = ini_left_value;
  assign w_b     = ini_right_value;
  assign w_shamt = w_b[SHW-1:0];

  // The extra bit on each shifter catches the last bit shifted out, which
  // becomes C; a zero shift leaves that bit at 0.
  assign w_sum  = {1'b0, w_a} + {1'b0, w_b};
  assign w_diff = {1'b0, w_a} - {1'b0, w_b};
  assign w_shl  = {1'b0, w_a} << w_shamt;
  assign w_shr  = {w_a, 1'b0} >> w_shamt;
  assign w_asr  = $unsigned($signed({w_a, 1'b0}) >>> w_shamt);

  // Architectural flags {N,Z,C,V}; only the low nibble of one register matters.
  assign w_arch_flags = registers[FLAGS_INDEX][3:0];
  assign w_unused     = ^registers;

  // ALU: result plus carry/overflow for the selected opcode.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_result   = '0;
    w_carry    = 1'b0;
    w_overflow = 1'b0;
    w_flag_en  = 1'b1;
    case (alu_op_e'(ini_operation))
      OP_ADD: begin
        w_result   = w_sum[W-1:0];
        w_carry    = w_sum[W];
        w_overflow = (w_a[W-1] == w_b[W-1]) && (w_sum[W-1] != w_a[W-1]);
      end
      OP_SUB: begin
        w_result   = w_diff[W-1:0];
        w_carry    = ~w_diff[W];
        w_overflow = (w_a[W-1] != w_b[W-1]) && (w_diff[W-1] != w_a[W-1]);
      end
      OP_AND: w_result = w_a & w_b;
      OP_OR:  w_result = w_a | w_b;
      OP_XOR: w_result = w_a ^ w_b;
      OP_SHL: begin
        w_result = w_shl[W-1:0];
        w_carry  = w_shl[W];
      end
      OP_SHR: begin
        w_result = w_shr[W:1];
        w_carry  = w_shr[0];
      end
      OP_ASR: begin
        w_result = w_asr[W:1];
        w_carry  = w_asr[0];
      end
      OP_MUL: w_result = w_a * w_b;
      OP_MOV: w_result = w_b;
      default: w_flag_en = 1'b0;
    endcase
  end

  // Result flags, forced to zero for bubbles and reserved opcodes.
  always_comb begin
    w_flags = 4'b0000;
    if (ini_is_valid && w_flag_en) begin
      w_flags = {w_result[W-1], (w_result == '0), w_carry, w_overflow};
    end
  end

  // Branch condition against the architectural flags; 0 means no redirect.
  always_comb begin
    w_take = 1'b0;
    case (adj_op_e'(ini_adjustment_operation))
      ADJ_NEVER:  w_take = 1'b0;
      ADJ_ALWAYS: w_take = 1'b1;
      ADJ_Z:      w_take = w_arch_flags[2];
      ADJ_NZ:     w_take = ~w_arch_flags[2];
      ADJ_N:      w_take = w_arch_flags[3];
      ADJ_NN:     w_take = ~w_arch_flags[3];
      ADJ_C:      w_take = w_arch_flags[1];
      ADJ_NC:     w_take = ~w_arch_flags[1];
      default:    w_take = 1'b0;
    endcase
    w_adjustment = (ini_is_valid && w_take) ? ini_adjustment : '0;
  end

  // Stall passes straight back to the read stage, suppressed during reset.
  assign ini_hold = outi_hold & ~reset;

  // Output register bank: loads every cycle unless the write stage stalls.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      outi_pc                    <= '0;
      outi_adjustment            <= '0;
      outi_destination_value     <= '0;
      outi_destination           <= '0;
      outi_flags                 <= '0;
      outi_destination_is_memory <= 1'b0;
      outi_has_flushed           <= 1'b0;
      outi_is_valid              <= 1'b0;
    end else if (!outi_hold) begin
      outi_pc                    <= ini_pc;
      outi_adjustment            <= w_adjustment;
      outi_destination_value     <= w_result;
      outi_destination           <= ini_destination;
      outi_flags                 <= w_flags;
      outi_destination_is_memory <= ini_destination_is_memory;
      outi_has_flushed           <= ini_has_flushed;
      outi_is_valid              <= ini_is_valid;
    end
  end

endmodule

// File: tb/tb_execute.sv
// Bench for the execute stage: a driver issues directed vectors and pushes
// hand-computed expectations into a queue; a monitor pops one expectation
// after every rising edge and compares it with the registered outputs.
module tb_execute;

  logic               clock;
  logic               reset;
  logic [31:0][31:0]  registers;
  logic [31:0]        ini_pc;
  logic [31:0]        ini_adjustment;
  logic [31:0]        ini_left_value;
  logic [31:0]        ini_right_value;
  logic [4:0]         ini_destination;
  logic [3:0]         ini_operation;
  logic [2:0]         ini_adjustment_operation;
  logic               ini_destination_is_memory;
  logic               ini_has_flushed;
  logic               ini_is_valid;
  logic               ini_hold;
  logic [31:0]        outi_pc;
  logic [31:0]        outi_adjustment;
  logic [31:0]        outi_destination_value;
  logic [4:0]         outi_destination;
  logic [3:0]         outi_flags;
  logic               outi_destination_is_memory;
  logic               outi_has_flushed;
  logic               outi_is_valid;
  logic               outi_hold;

  execute #(.W(32), .NR(32), .FLAGS_INDEX(31)) dut (
    .clock                      (clock),
    .reset                      (reset),
    .registers                  (registers),
    .ini_pc                     (ini_pc),
    .ini_adjustment             (ini_adjustment),
    .ini_left_value             (ini_left_value),
    .ini_right_value            (ini_right_value),
    .ini_destination            (ini_destination),
    .ini_operation              (ini_operation),
    .ini_adjustment_operation   (ini_adjustment_operation),
    .ini_destination_is_memory  (ini_destination_is_memory),
    .ini_has_flushed            (ini_has_flushed),
    .ini_is_valid               (ini_is_valid),
    .ini_hold                   (ini_hold),
    .outi_pc                    (outi_pc),
    .outi_adjustment            (outi_adjustment),
    .outi_destination_value     (outi_destination_value),
    .outi_destination           (outi_destination),
    .outi_flags                 (outi_flags),
    .outi_destination_is_memory (outi_destination_is_memory),
    .outi_has_flushed           (outi_has_flushed),
    .outi_is_valid              (outi_is_valid),
    .outi_hold                  (outi_hold)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] adj;
    logic [31:0] val;
    logic [4:0]  dest;
    logic [3:0]  flags;
    logic        mem;
    logic        fl;
    logic        valid;
    logic        hold;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_exp;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  function automatic logic [127:0] pack_out();
    return {19'd0, outi_pc, outi_adjustment, outi_destination_value, outi_destination,
            outi_flags, outi_destination_is_memory, outi_has_flushed, outi_is_valid, ini_hold};
  endfunction

  function automatic logic [127:0] pack_exp(input exp_t e);
    return {19'd0, e.pc, e.adj, e.val, e.dest, e.flags, e.mem, e.fl, e.valid, e.hold};
  endfunction

  // Monitor: one expectation per rising edge, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      if (exp_q.size() > 0) begin
        #1;
        e = exp_q.pop_front();
        check(e.name, pack_out(), pack_exp(e));
      end
    end
  end

  // Drive one instruction at the falling edge and queue its expected result.
  task automatic issue(input string name, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] pc, input logic [4:0] dest,
                       input logic [2:0] adj_op, input logic [31:0] adj, input logic valid,
                       input logic mem, input logic fl, input logic [31:0] e_val,
                       input logic [3:0] e_flags, input logic [31:0] e_adj);
    exp_t e;
    @(negedge clock);
    ini_operation             = op;
    ini_left_value            = a;
    ini_right_value           = b;
    ini_pc                    = pc;
    ini_destination           = dest;
    ini_adjustment_operation  = adj_op;
    ini_adjustment            = adj;
    ini_is_valid              = valid;
    ini_destination_is_memory = mem;
    ini_has_flushed           = fl;
    outi_hold                 = 1'b0;
    e.name = name; e.pc = pc; e.adj = e_adj; e.val = e_val; e.dest = dest;
    e.flags = e_flags; e.mem = mem; e.fl = fl; e.valid = valid; e.hold = 1'b0;
    last_exp = e;
    exp_q.push_back(e);
  endtask

  // Stall one cycle with changed inputs; outputs must stay at the prior result.
  task automatic stall(input string name, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    @(negedge clock);
    ini_operation   = 4'd0;
    ini_left_value  = a;
    ini_right_value = b;
    ini_pc          = 32'h999;
    ini_destination = 5'd9;
    outi_hold       = 1'b1;
    e = last_exp;
    e.name = name;
    e.hold = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic check_reset_state(input string name);
    check(name, pack_out(), 128'd0);
  endtask

  initial begin
    registers = '0;
    ini_pc = 32'h55; ini_adjustment = 32'h77; ini_left_value = 32'h1; ini_right_value = 32'h2;
    ini_destination = 5'd7; ini_operation = 4'd0; ini_adjustment_operation = 3'b001;
    ini_destination_is_memory = 1'b1; ini_has_flushed = 1'b1; ini_is_valid = 1'b1;
    outi_hold = 1'b1;
    reset = 1'b1;

    // Reset with live inputs and a simultaneous hold: reset wins.
    repeat (2) @(posedge clock);
    #1 check_reset_state("reset_state");
    @(negedge clock);
    reset = 1'b0;
    outi_hold = 1'b0;
    ini_is_valid = 1'b0;

    issue("add_basic", 4'd0, 32'd5, 32'd3, 32'h100, 5'd2, 3'b000, 32'h0, 1, 0, 0, 32'h8, 4'b0000, 32'h0);
    issue("add_ovf",  4'd0, 32'h7FFFFFFF, 32'h1, 32'h104, 5'd3, 3'b000, 32'h0, 1, 0, 0, 32'h80000000, 4'b1001, 32'h0);
    issue("add_carry", 4'd0, 32'hFFFFFFFF, 32'h1, 32'h108, 5'd4, 3'b000, 32'h0, 1, 0, 0, 32'h0, 4'b0110, 32'h0);
    issue("sub_eq",   4'd1, 32'd3, 32'd3, 32'h10C, 5'd5, 3'b000, 32'h0, 1, 0, 0, 32'h0, 4'b0110, 32'h0);
    issue("sub_borrow", 4'd1, 32'd2, 32'd3, 32'h110, 5'd6, 3'b000, 32'h0, 1, 0, 0, 32'hFFFFFFFF, 4'b1000, 32'h0);
    issue("shr_carry", 4'd6, 32'h80000001, 32'd1, 32'h114, 5'd7, 3'b000, 32'h0, 1, 0, 0, 32'h40000000, 4'b0010, 32'h0);
    issue("asr_neg",  4'd7, 32'h80000000, 32'd4, 32'h118, 5'd8, 3'b000, 32'h0, 1, 0, 0, 32'hF8000000, 4'b1000, 32'h0);
    issue("shl_carry", 4'd5, 32'h80000001, 32'd1, 32'h11C, 5'd9, 3'b000, 32'h0, 1, 0, 0, 32'h2, 4'b0010, 32'h0);
    issue("shl_zero_amt", 4'd5, 32'h80000000, 32'h20, 32'h120, 5'd10, 3'b000, 32'h0, 1, 0, 0, 32'h80000000, 4'b1000, 32'h0);
    issue("xor_zero", 4'd4, 32'hFF, 32'hFF, 32'h124, 5'd11, 3'b000, 32'h0, 1, 0, 0, 32'h0, 4'b0100, 32'h0);
    issue("and",      4'd2, 32'hF0F0, 32'hFF00, 32'h128, 5'd12, 3'b000, 32'h0, 1, 0, 0, 32'hF000, 4'b0000, 32'h0);
    issue("or",       4'd3, 32'hF0F0, 32'h0F00, 32'h12C, 5'd13, 3'b000, 32'h0, 1, 0, 0, 32'hFFF0, 4'b0000, 32'h0);
    issue("mul",      4'd8, 32'd6, 32'd7, 32'h130, 5'd14, 3'b000, 32'h0, 1, 0, 0, 32'd42, 4'b0000, 32'h0);
    issue("mul_trunc", 4'd8, 32'h10000, 32'h10001, 32'h134, 5'd15, 3'b000, 32'h0, 1, 0, 0, 32'h10000, 4'b0000, 32'h0);
    issue("op_reserved", 4'd12, 32'd5, 32'd5, 32'h138, 5'd16, 3'b000, 32'h0, 1, 0, 0, 32'h0, 4'b0000, 32'h0);

    // Adjustment conditions with architectural flags Z=1, N=C=0.
    @(negedge clock);
    registers[31] = 32'h4;
    exp_q.push_back(last_exp);
    issue("adj_z",      4'd9, 32'd0, 32'd1, 32'h200, 5'd1, 3'b010, 32'h20, 1, 0, 0, 32'h1, 4'b0000, 32'h20);
    issue("adj_nz",     4'd9, 32'd0, 32'd1, 32'h204, 5'd1, 3'b011, 32'h20, 1, 0, 0, 32'h1, 4'b0000, 32'h0);
    issue("adj_always", 4'd9, 32'd0, 32'd1, 32'h208, 5'd1, 3'b001, 32'h20, 1, 0, 0, 32'h1, 4'b0000, 32'h20);
    issue("adj_never",  4'd9, 32'd0, 32'd1, 32'h20C, 5'd1, 3'b000, 32'h20, 1, 0, 0, 32'h1, 4'b0000, 32'h0);
    issue("adj_n",      4'd9, 32'd0, 32'd1, 32'h210, 5'd1, 3'b100, 32'h20, 1, 0, 0, 32'h1, 4'b0000, 32'h0);
    issue("adj_nn",     4'd9, 32'd0, 32'd1, 32'h214, 5'd1, 3'b101, 32'h20, 1, 0, 0, 32'h1, 4'b0000, 32'h20);
    issue("adj_c",      4'd9, 32'd0, 32'd1, 32'h218, 5'd1, 3'b110, 32'h20, 1, 0, 0, 32'h1, 4'b0000, 32'h0);
    issue("adj_nc",     4'd9, 32'd0, 32'd1, 32'h21C, 5'd1, 3'b111, 32'h20, 1, 0, 0, 32'h1, 4'b0000, 32'h20);
    issue("adj_invalid", 4'd9, 32'd0, 32'd1, 32'h220, 5'd1, 3'b001, 32'h20, 0, 0, 0, 32'h1, 4'b0000, 32'h0);

    // Hold: two frozen cycles, then the pending inputs register.
    issue("pre_hold", 4'd0, 32'd1, 32'd1, 32'h300, 5'd20, 3'b000, 32'h0, 1, 0, 0, 32'h2, 4'b0000, 32'h0);
    stall("hold_1", 32'd10, 32'd10);
    stall("hold_2", 32'd11, 32'd11);
    issue("post_hold", 4'd0, 32'd10, 32'd10, 32'h304, 5'd21, 3'b000, 32'h0, 1, 0, 0, 32'd20, 4'b0000, 32'h0);

    issue("pass_mov", 4'd9, 32'd0, 32'hDEADBEEF, 32'h400, 5'd30, 3'b000, 32'h0, 1, 1, 1, 32'hDEADBEEF, 4'b1000, 32'h0);

    // Asynchronous reset mid-cycle, then normal operation after release.
    @(negedge clock);
    @(posedge clock);
    #3 reset = 1'b1;
    #1 check_reset_state("async_reset");
    @(negedge clock);
    reset = 1'b0;
    issue("after_reset", 4'd0, 32'd5, 32'd3, 32'h100, 5'd2, 3'b000, 32'h0, 1, 0, 0, 32'h8, 4'b0000, 32'h0);

    repeat (3) @(negedge clock);
    check("queue_drained", 128'(exp_q.size()), 128'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/execute.md
Name: execute

Overview:
- Execute stage of the pipelined CPU, between the register-read stage (i_read_to_execute) and the write stage (i_execute_to_write).
- Performs one ALU operation per valid instruction and produces result flags.
- Resolves the PC adjustment (branch offset) against architectural flags and registers everything for the write stage with one-cycle latency.
- Applies back-pressure from the write stage to the read stage.

Parameters:
- W, 32, data/PC width.
- NR, 32, number of architectural registers (regfile_t is NR x W).
- FLAGS_INDEX, NR-1, register whose low 4 bits hold the architectural flags {N,Z,C,V}.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- registers  in  NR x W  architectural register file snapshot.
- ini_pc  in  W  instruction PC.
- ini_adjustment  in  W  PC offset candidate.
- ini_left_value  in  W  operand A.
- ini_right_value  in  W  operand B.
- ini_destination  in  5  destination register index.
- ini_operation  in  4  ALU opcode.
- ini_adjustment_operation  in  3  adjustment condition code.
- ini_destination_is_memory  in  1  result is a memory target.
- ini_has_flushed  in  1  flush epoch tag.
- ini_is_valid  in  1  instruction valid.
- ini_hold  out  1  stall request to the read stage.
- outi_pc  out  W  registered PC.
- outi_adjustment  out  W  resolved offset; 0 means no redirect.
- outi_destination_value  out  W  ALU result.
- outi_destination  out  5  destination index.
- outi_flags  out  4  {N,Z,C,V} of the result.
- outi_destination_is_memory  out  1  passed through.
- outi_has_flushed  out  1  passed through.
- outi_is_valid  out  1  valid to the write stage.
- outi_hold  in  1  stall from the write stage.

Behaviour:
- Reset (asynchronous, active-high): every outi_* output clears to 0; ini_hold = 0 while reset is asserted.
- Latency: one cycle. Inputs are sampled on the rising clock edge; results appear on outi_* after that edge.
- Hold: ini_hold = outi_hold (combinational). While outi_hold = 1, all outi_* registers keep their values and inputs are ignored.
- Flow: ini_is_valid = 0 -> outi_is_valid = 0, outi_adjustment = 0, outi_flags = 0. Other fields are still registered.
- Pass-through: pc, destination, destination_is_memory and has_flushed are copied unchanged.
- ALU opcodes (A = left_value, B = right_value, results truncated to W bits):
  - 0 ADD: A+B; C = carry out; V = signed overflow.
  - 1 SUB: A-B; C = 1 when no borrow (A >= B unsigned); V = signed overflow.
  - 2 AND, 3 OR, 4 XOR, 9 MOV (result = B): C = V = 0.
  - 5 SHL, 6 SHR (logical), 7 ASR: shift amount = B[4:0]; C = last bit shifted out (0 for amount 0); V = 0.
  - 8 MUL: low W bits of A*B; C = V = 0.
  - 10-15: result 0, flags 0.
- N = result[W-1]; Z = (result == 0). Flags are computed only for valid instructions.
- Adjustment: F = registers[FLAGS_INDEX][3:0] = {N,Z,C,V}. outi_adjustment = ini_adjustment if the condition holds, else 0. Conditions:
  - 000 never; 001 always.
  - 010 Z; 011 !Z.
  - 100 N; 101 !N.
  - 110 C; 111 !C.
- Simultaneous reset and hold: reset wins.
- Reset deasserted mid-operation: the first valid instruction after release is processed normally.
- Implementation is combinational ALU plus one output register bank, with no internal state machine.

Test Plan:
- Reset: reset = 1 with any inputs -> all outi_* = 0 and ini_hold = 0. Release reset and apply ADD 5+3, pc = 0x100, dest = 2, valid -> next cycle destination_value = 0x8, flags = 0000, pc = 0x100, destination = 2, is_valid = 1.
- Overflow/carry:
  - ADD 0x7FFFFFFF+1 -> 0x80000000, flags N=1 V=1 (1001).
  - ADD 0xFFFFFFFF+1 -> 0, flags Z=1 C=1 (0110).
  - SUB 3-3 -> 0, flags 0110.
- Shifts and logic:
  - SHR 0x80000001 by 1 -> 0x40000000, C=1.
  - ASR 0x80000000 by 4 -> 0xF8000000, N=1.
  - XOR 0xFF^0xFF -> 0, Z=1.
- Adjustment with adjustment = 0x20:
  - registers[31] = 0x4 (Z=1), op 010 -> outi_adjustment = 0x20.
  - op 011 -> 0.
  - op 001 -> 0x20.
  - op 000 -> 0.
  - is_valid = 0 with op 001 -> 0 and outi_is_valid = 0.
- Hold: outi_hold = 1 for 2 cycles while inputs change -> ini_hold = 1 and outputs frozen at the prior result. Deassert -> the new inputs are registered on the next edge.
- Pass-through: destination_is_memory = 1, has_flushed = 1, MOV B = 0xDEADBEEF -> outputs 1, 1, 0xDEADBEEF, flags 1000.
